// File: rtl/pipe_hazard_unit.sv
// Hazard controller for a 5-stage pipeline: tracks EX/ME destinations, raises stall/flush,
// and registers the EX-stage forwarding selects. Saturating stall/flush event counters.
module pipe_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter bit FWD_EN     = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  enable,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_use_rs_i,
  input  logic                  id_use_rt_i,
  input  logic [REG_ADDR_W-1:0] id_waddr_i,
  input  logic                  id_reg_write_i,
  input  logic                  id_mem_read_i,
  input  logic                  redirect_i,
  input  logic                  clr_cnt_i,
  output logic                  stall_o,
  output logic                  flush_o,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  localparam logic [1:0]       SEL_RF   = 2'b00;
  localparam logic [1:0]       SEL_EXME = 2'b01;
  localparam logic [1:0]       SEL_MEWB = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic                  r_ex_valid, r_ex_rw, r_ex_mr;
  logic [REG_ADDR_W-1:0] r_ex_waddr;
  logic                  r_me_valid, r_me_rw, r_me_mr;
  logic [REG_ADDR_W-1:0] r_me_waddr;
  logic [1:0]            r_fwd_a, r_fwd_b;
  logic [CNT_W-1:0]      r_stall_cnt, r_flush_cnt;

  logic       w_ex_rs, w_ex_rt, w_me_rs, w_me_rt;
  logic       w_stall_cond, w_stall;
  logic [1:0] w_fwd_a, w_fwd_b;

  // $0 is hardwired, so a write to it never creates a dependency.
  assign w_ex_rs = r_ex_valid && r_ex_rw && (r_ex_waddr == id_rs_i) && (id_rs_i != '0) && id_use_rs_i;
  assign w_ex_rt = r_ex_valid && r_ex_rw && (r_ex_waddr == id_rt_i) && (id_rt_i != '0) && id_use_rt_i;
  assign w_me_rs = r_me_valid && r_me_rw && (r_me_waddr == id_rs_i) && (id_rs_i != '0) && id_use_rs_i;
  assign w_me_rt = r_me_valid && r_me_rw && (r_me_waddr == id_rt_i) && (id_rt_i != '0) && id_use_rt_i;

  always_comb begin
    w_stall_cond = 1'b0;
    w_fwd_a      = SEL_RF;
    w_fwd_b      = SEL_RF;
    if (FWD_EN) begin
      w_stall_cond = id_valid_i && r_ex_mr && (w_ex_rs || w_ex_rt);
      // The younger producer in EX holds the newest value.
      if (w_ex_rs)      w_fwd_a = SEL_EXME;
      else if (w_me_rs) w_fwd_a = SEL_MEWB;
      if (w_ex_rt)      w_fwd_b = SEL_EXME;
      else if (w_me_rt) w_fwd_b = SEL_MEWB;
    end else begin
      w_stall_cond = id_valid_i && (w_ex_rs || w_ex_rt || w_me_rs || w_me_rt);
    end
  end

  assign w_stall = w_stall_cond && !redirect_i;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_ex_valid  <= 1'b0;
      r_ex_rw     <= 1'b0;
      r_ex_mr     <= 1'b0;
      r_ex_waddr  <= '0;
      r_me_valid  <= 1'b0;
      r_me_rw     <= 1'b0;
      r_me_mr     <= 1'b0;
      r_me_waddr  <= '0;
      r_fwd_a     <= SEL_RF;
      r_fwd_b     <= SEL_RF;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (enable) begin
      if (redirect_i) begin
        r_ex_valid <= 1'b0;
        r_ex_rw    <= 1'b0;
        r_ex_mr    <= 1'b0;
        r_ex_waddr <= '0;
        r_me_valid <= 1'b0;
        r_me_rw    <= 1'b0;
        r_me_mr    <= 1'b0;
        r_me_waddr <= '0;
        r_fwd_a    <= SEL_RF;
        r_fwd_b    <= SEL_RF;
      end else begin
        r_me_valid <= r_ex_valid;
        r_me_rw    <= r_ex_rw;
        r_me_mr    <= r_ex_mr;
        r_me_waddr <= r_ex_waddr;
        if (w_stall) begin
          r_ex_valid <= 1'b0;
          r_ex_rw    <= 1'b0;
          r_ex_mr    <= 1'b0;
          r_ex_waddr <= '0;
          r_fwd_a    <= SEL_RF;
          r_fwd_b    <= SEL_RF;
        end else begin
          r_ex_valid <= id_valid_i;
          r_ex_rw    <= id_reg_write_i;
          r_ex_mr    <= id_mem_read_i;
          r_ex_waddr <= id_waddr_i;
          r_fwd_a    <= w_fwd_a;
          r_fwd_b    <= w_fwd_b;
        end
      end
      if (clr_cnt_i) begin
        r_stall_cnt <= '0;
        r_flush_cnt <= '0;
      end else begin
        if (redirect_i && (r_flush_cnt != CNT_MAX)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        if (w_stall && (r_stall_cnt != CNT_MAX))    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_o     = w_stall;
  assign flush_o     = redirect_i;
  assign fwd_a_o     = r_fwd_a;
  assign fwd_b_o     = r_fwd_b;
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: one forwarding instance, one no-forwarding instance,
// and a 2-bit-counter instance, all driven from the same ID/redirect stimulus.
module tb_pipe_hazard_unit;

  logic       clk, arst_n, enable;
  logic       id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read;
  logic [4:0] id_rs, id_rt, id_waddr;
  logic       redirect, clr_cnt;

  logic        s1, f1, s0, f0, s2, f2;
  logic [1:0]  fa1, fb1, fa0, fb0, fa2, fb2;
  logic [15:0] sc1, fc1, sc0, fc0;
  logic [1:0]  sc2, fc2;

  int n_vec = 0;
  int n_err = 0;

  pipe_hazard_unit #(.REG_ADDR_W(5), .FWD_EN(1'b1), .CNT_W(16)) u_fwd (
    .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid_i(id_valid),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt),
    .id_waddr_i(id_waddr), .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read),
    .redirect_i(redirect), .clr_cnt_i(clr_cnt), .stall_o(s1), .flush_o(f1),
    .fwd_a_o(fa1), .fwd_b_o(fb1), .stall_cnt_o(sc1), .flush_cnt_o(fc1));

  pipe_hazard_unit #(.REG_ADDR_W(5), .FWD_EN(1'b0), .CNT_W(16)) u_nofwd (
    .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid_i(id_valid),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt),
    .id_waddr_i(id_waddr), .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read),
    .redirect_i(redirect), .clr_cnt_i(clr_cnt), .stall_o(s0), .flush_o(f0),
    .fwd_a_o(fa0), .fwd_b_o(fb0), .stall_cnt_o(sc0), .flush_cnt_o(fc0));

  pipe_hazard_unit #(.REG_ADDR_W(5), .FWD_EN(1'b1), .CNT_W(2)) u_small (
    .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid_i(id_valid),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt),
    .id_waddr_i(id_waddr), .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read),
    .redirect_i(redirect), .clr_cnt_i(clr_cnt), .stall_o(s2), .flush_o(f2),
    .fwd_a_o(fa2), .fwd_b_o(fb2), .stall_cnt_o(sc2), .flush_cnt_o(fc2));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic [4:0] wa,
                          input logic rw, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_waddr = wa; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic id_idle();
    id_instr(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    arst_n = 1'b0; enable = 1'b1; redirect = 1'b0; clr_cnt = 1'b0;
    id_idle();
    #3;
    @(negedge clk);
    arst_n = 1'b1;
    tick();
  endtask

  // Tests
  task automatic test_reset();
    arst_n = 1'b0; enable = 1'b1; clr_cnt = 1'b0; redirect = 1'b1;
    id_idle();
    #2;
    n_vec++; if (f1 !== 1'b1) begin n_err++; $display("FAIL rst_flush_follows got=%0b exp=1", f1); end
    n_vec++; if (s1 !== 1'b0) begin n_err++; $display("FAIL rst_stall got=%0b exp=0", s1); end
    redirect = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    tick();
    #1;
    n_vec++; if (s1 !== 1'b0 || s0 !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%0b/%0b exp=0/0", s1, s0); end
    n_vec++; if (f1 !== 1'b0) begin n_err++; $display("FAIL reset_flush got=%0b exp=0", f1); end
    n_vec++; if (fa1 !== 2'b00 || fb1 !== 2'b00) begin n_err++; $display("FAIL reset_fwd got=%b/%b exp=00/00", fa1, fb1); end
    n_vec++; if (sc1 !== 16'd0 || fc1 !== 16'd0) begin n_err++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", sc1, fc1); end
    n_vec++; if (sc2 !== 2'd0 || fc2 !== 2'd0) begin n_err++; $display("FAIL reset_cnt_small got=%0d/%0d exp=0/0", sc2, fc2); end
  endtask

  task automatic test_load_use();
    do_reset();
    id_instr(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);  // lw $3,0($1)
    #1;
    n_vec++; if (s1 !== 1'b0) begin n_err++; $display("FAIL lu_no_stall_on_load got=%0b exp=0", s1); end
    tick();
    id_instr(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);  // add $4,$3,$5
    #1;
    n_vec++; if (s1 !== 1'b1) begin n_err++; $display("FAIL lu_stall got=%0b exp=1", s1); end
    tick();
    n_vec++; if (sc1 !== 16'd1) begin n_err++; $display("FAIL lu_stall_cnt got=%0d exp=1", sc1); end
    n_vec++; if (fa1 !== 2'b00) begin n_err++; $display("FAIL lu_bubble_fwd got=%b exp=00", fa1); end
    #1;
    n_vec++; if (s1 !== 1'b0) begin n_err++; $display("FAIL lu_single_stall got=%0b exp=0", s1); end
    tick();
    n_vec++; if (fa1 !== 2'b10 || fb1 !== 2'b00) begin n_err++; $display("FAIL lu_fwd got=%b/%b exp=10/00", fa1, fb1); end
    n_vec++; if (sc1 !== 16'd1) begin n_err++; $display("FAIL lu_stall_cnt_hold got=%0d exp=1", sc1); end
    id_idle();
  endtask

  task automatic test_forward();
    do_reset();
    id_instr(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);  // add $3,$1,$2
    tick();
    id_instr(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);  // sub $6,$3,$3
    #1;
    n_vec++; if (s1 !== 1'b0) begin n_err++; $display("FAIL fw_no_stall got=%0b exp=0", s1); end
    tick();
    n_vec++; if (fa1 !== 2'b01 || fb1 !== 2'b01) begin n_err++; $display("FAIL fw_ex got=%b/%b exp=01/01", fa1, fb1); end
    // Two producers of $3 in EX and ME: EX must win.
    do_reset();
    id_instr(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    id_instr(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    id_instr(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    tick();
    n_vec++; if (fa1 !== 2'b01 || fb1 !== 2'b01) begin n_err++; $display("FAIL fw_ex_over_me got=%b/%b exp=01/01", fa1, fb1); end
    n_vec++; if (fa0 !== 2'b00 || fb0 !== 2'b00) begin n_err++; $display("FAIL fw_off_fwd got=%b/%b exp=00/00", fa0, fb0); end
    // Producer only in ME.
    do_reset();
    id_instr(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    id_instr(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
    tick();
    id_instr(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    tick();
    n_vec++; if (fa1 !== 2'b10 || fb1 !== 2'b10) begin n_err++; $display("FAIL fw_me got=%b/%b exp=10/10", fa1, fb1); end
    id_idle();
  endtask

  task automatic test_zero_reg();
    do_reset();
    id_instr(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);  // lw $0
    tick();
    id_instr(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);  // add $8,$0,$0
    #1;
    n_vec++; if (s1 !== 1'b0 || s0 !== 1'b0) begin n_err++; $display("FAIL zero_stall got=%0b/%0b exp=0/0", s1, s0); end
    tick();
    n_vec++; if (fa1 !== 2'b00 || fb1 !== 2'b00) begin n_err++; $display("FAIL zero_fwd got=%b/%b exp=00/00", fa1, fb1); end
    id_instr(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);  // $0 producer now in ME for u_nofwd
    #1;
    n_vec++; if (s0 !== 1'b0) begin n_err++; $display("FAIL zero_stall_me got=%0b exp=0", s0); end
    id_idle();
  endtask

  task automatic test_no_fwd();
    do_reset();
    id_instr(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);  // add $3,$1,$2
    tick();
    id_instr(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);  // or $7,$3,$1
    #1;
    n_vec++; if (s0 !== 1'b1) begin n_err++; $display("FAIL nf_stall1 got=%0b exp=1", s0); end
    tick();
    n_vec++; if (sc0 !== 16'd1) begin n_err++; $display("FAIL nf_cnt1 got=%0d exp=1", sc0); end
    #1;
    n_vec++; if (s0 !== 1'b1) begin n_err++; $display("FAIL nf_stall2 got=%0b exp=1", s0); end
    tick();
    #1;
    n_vec++; if (s0 !== 1'b0) begin n_err++; $display("FAIL nf_release got=%0b exp=0", s0); end
    tick();
    n_vec++; if (sc0 !== 16'd2) begin n_err++; $display("FAIL nf_cnt2 got=%0d exp=2", sc0); end
    n_vec++; if (fa0 !== 2'b00 || fb0 !== 2'b00) begin n_err++; $display("FAIL nf_fwd got=%b/%b exp=00/00", fa0, fb0); end
    id_idle();
  endtask

  task automatic test_redirect();
    do_reset();
    id_instr(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);  // lw $3
    tick();
    id_instr(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);  // add $4,$3,$5
    redirect = 1'b1;
    #1;
    n_vec++; if (s1 !== 1'b0 || f1 !== 1'b1) begin n_err++; $display("FAIL rd_priority got=s%0b/f%0b exp=s0/f1", s1, f1); end
    tick();
    redirect = 1'b0;
    n_vec++; if (fc1 !== 16'd1 || sc1 !== 16'd0) begin n_err++; $display("FAIL rd_cnt got=f%0d/s%0d exp=f1/s0", fc1, sc1); end
    #1;
    n_vec++; if (s1 !== 1'b0) begin n_err++; $display("FAIL rd_sb_empty got=%0b exp=0", s1); end
    tick();
    n_vec++; if (fa1 !== 2'b00) begin n_err++; $display("FAIL rd_fwd got=%b exp=00", fa1); end
    id_idle();
  endtask

  task automatic test_saturate();
    do_reset();
    redirect = 1'b1;
    tick(); tick();
    n_vec++; if (fc2 !== 2'd2) begin n_err++; $display("FAIL sat_mid got=%0d exp=2", fc2); end
    tick(); tick(); tick();
    n_vec++; if (fc2 !== 2'd3) begin n_err++; $display("FAIL sat_top got=%0d exp=3", fc2); end
    n_vec++; if (fc1 !== 16'd5) begin n_err++; $display("FAIL sat_wide got=%0d exp=5", fc1); end
    clr_cnt = 1'b1;  // clear wins over the concurrent flush increment
    tick();
    n_vec++; if (fc2 !== 2'd0 || fc1 !== 16'd0) begin n_err++; $display("FAIL sat_clr got=%0d/%0d exp=0/0", fc2, fc1); end
    clr_cnt = 1'b0; redirect = 1'b0;
    tick();
    n_vec++; if (fc2 !== 2'd0) begin n_err++; $display("FAIL sat_after_clr got=%0d exp=0", fc2); end
  endtask

  task automatic test_enable();
    do_reset();
    id_instr(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);  // lw $3
    tick();
    enable = 1'b0;
    id_instr(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    tick(); tick();
    #1;
    n_vec++; if (s1 !== 1'b1) begin n_err++; $display("FAIL en_frozen_stall got=%0b exp=1", s1); end
    n_vec++; if (sc1 !== 16'd0) begin n_err++; $display("FAIL en_no_count got=%0d exp=0", sc1); end
    redirect = 1'b1;
    #1;
    n_vec++; if (f1 !== 1'b1 || s1 !== 1'b0) begin n_err++; $display("FAIL en_comb got=f%0b/s%0b exp=f1/s0", f1, s1); end
    tick();
    n_vec++; if (fc1 !== 16'd0) begin n_err++; $display("FAIL en_no_flush_cnt got=%0d exp=0", fc1); end
    redirect = 1'b0; enable = 1'b1;
    tick();
    n_vec++; if (sc1 !== 16'd1) begin n_err++; $display("FAIL en_resume got=%0d exp=1", sc1); end
    id_idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    id_instr(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    id_instr(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    tick();  // u_nofwd now mid-stall with producer in ME
    arst_n = 1'b0;
    #1;
    n_vec++; if (s0 !== 1'b0 || sc0 !== 16'd0) begin n_err++; $display("FAIL ar_clear got=s%0b/c%0d exp=s0/c0", s0, sc0); end
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    n_vec++; if (s0 !== 1'b0) begin n_err++; $display("FAIL ar_empty got=%0b exp=0", s0); end
    tick();
    n_vec++; if (sc0 !== 16'd0) begin n_err++; $display("FAIL ar_no_cnt got=%0d exp=0", sc0); end
    id_idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_zero_reg();
    test_no_fwd();
    test_redirect();
    test_saturate();
    test_enable();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
